fft_frame_cap: RTL and testbench



---
 rtl/fft_cap_pkg.sv | 30 +++
 rtl/fft_frame_cap_ram.sv | 41 ++++
 rtl/fft_frame_cap.sv | 245 ++++++++++++++++++++++++
 tb/tb_fft_frame_cap.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_cap_pkg.sv
// ----------------------------------------------------------------------------
// fft_cap_pkg
// Shared types and helpers for the FFT frame-capture block.
//   state_e        : capture FSM states (IDLE, FILL, DRAIN)
//   FRAME_LEN_DEF  : default samples per frame
//   DC_OFFSET_DEF  : default mid-scale offset removed from each sample
//   clog2()        : ceiling log2, used to size pointers and counters
// ----------------------------------------------------------------------------
package fft_cap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int FRAME_LEN_DEF = 256;
    localparam int DC_OFFSET_DEF = 1023;

    // Returns 0 for value <= 1; callers that need a non-zero width clamp it.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_cap_ram.sv
// ----------------------------------------------------------------------------
// frame_ram
// Simple dual-port frame buffer, DEPTH x WIDTH, one clock for both ports.
// The read port is registered (1-cycle latency) and only updates when re=1,
// so rdata holds its value while the consumer is stalled.
// Ports:
//   clk            : clock
//   we/waddr/wdata : write port
//   re/raddr       : read request
//   rdata          : read data, valid the cycle after re
// ----------------------------------------------------------------------------
module frame_ram
    import fft_cap_pkg::*;
#(
    parameter int DEPTH = FRAME_LEN_DEF,
    parameter int WIDTH = 12,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto block RAM; every
    // entry is written during FILL before DRAIN ever reads it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_frame_cap.sv
// ----------------------------------------------------------------------------
// fft_frame_cap
// Captures an offset-binary ADC stream into a frame buffer (optionally
// decimated), removes the DC offset, and streams each full frame to the FFT
// sink with valid/ready, sop and eop.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : pulse; arms capture, or restarts it from scratch
//   cont                : 1 = continuous frames, 0 = one-shot (sampled at eop)
//   sample_en/sample_in : input sample strobe and data
//   otr                 : ADC over-range, qualified by sample_en
//   out_valid/out_ready : output handshake
//   out_data            : signed sample (sample_in - DC_OFFSET)
//   out_sop/out_eop     : first / last beat of a frame
//   frame_otr           : over-range summary, valid on the eop beat
//   busy                : FSM not idle
//   frame_done          : pulse the cycle after the eop transfer
// Build option: define OTR_FLAG_EN to report over-range per frame; otherwise
// otr is ignored and frame_otr is 0.
// ----------------------------------------------------------------------------
module fft_frame_cap
    import fft_cap_pkg::*;
#(
    parameter int DATA_W    = 11,
    parameter int OUT_W     = 12,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int DECIM     = 1,
    parameter int DC_OFFSET = DC_OFFSET_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              otr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              frame_otr,
    output logic              busy,
    output logic              frame_done
);

    localparam int PTR_W  = clog2(FRAME_LEN);
    localparam int DCNT_W = (DECIM > 1) ? clog2(DECIM) : 1;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [PTR_W:0]     rptr_q, rptr_d;      // MSB set once every entry has been read
    logic [PTR_W-1:0]   ridx_q, ridx_d;      // index of the word sitting on the RAM output
    logic               rv_q, rv_d;          // RAM output holds a word not yet loaded
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_sop_q, out_sop_d;
    logic               out_eop_q, out_eop_d;
    logic               frame_done_q, frame_done_d;

    logic               accept;
    logic               load;
    logic               xfer;
    logic               clr;
    logic               ram_re;
    logic [OUT_W-1:0]   ram_wdata;
    logic [OUT_W-1:0]   ram_rdata;

    // Offset-binary to two's complement: zero-extend, then remove mid-scale.
    assign ram_wdata = {1'b0, sample_in} - OUT_W'(DC_OFFSET);
    assign xfer      = out_valid_q && out_ready;

    frame_ram #(
        .DEPTH (FRAME_LEN),
        .WIDTH (OUT_W),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wptr_q),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rptr_q[PTR_W-1:0]),
        .rdata (ram_rdata)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        dcnt_d       = dcnt_q;
        rptr_d       = rptr_q;
        ridx_d       = ridx_q;
        rv_d         = rv_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sop_d    = out_sop_q;
        out_eop_d    = out_eop_q;
        frame_done_d = 1'b0;
        accept       = 1'b0;
        load         = 1'b0;
        ram_re       = 1'b0;
        clr          = 1'b0;

        case (state_q)
            FILL: begin
                if (sample_en) begin
                    if (dcnt_q == DCNT_W'(DECIM - 1)) begin
                        dcnt_d = '0;
                        accept = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                        if (wptr_q == PTR_W'(FRAME_LEN - 1)) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end

            DRAIN: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                end
                // Move the prefetched word into the output register whenever
                // the output is empty or being drained this cycle.
                load = rv_q && (!out_valid_q || out_ready);
                if (load) begin
                    out_valid_d = 1'b1;
                    out_data_d  = ram_rdata;
                    out_sop_d   = (ridx_q == '0);
                    out_eop_d   = (ridx_q == PTR_W'(FRAME_LEN - 1));
                    rv_d        = 1'b0;
                end
                // Keep the RAM output stage full: issue the next read as soon
                // as its current word is (or is about to be) consumed.
                if (!rptr_q[PTR_W] && (!rv_q || load)) begin
                    ram_re = 1'b1;
                    ridx_d = rptr_q[PTR_W-1:0];
                    rptr_d = rptr_q + 1'b1;
                    rv_d   = 1'b1;
                end
                if (xfer && out_eop_q) begin
                    state_d      = cont ? FILL : IDLE;
                    frame_done_d = 1'b1;
                    clr          = 1'b1;
                end
            end

            default: ;
        endcase

        // start overrides everything, including a coincident eop handshake.
        if (start) begin
            state_d      = FILL;
            frame_done_d = 1'b0;
            accept       = 1'b0;
            ram_re       = 1'b0;
            clr          = 1'b1;
        end

        if (clr) begin
            wptr_d      = '0;
            dcnt_d      = '0;
            rptr_d      = '0;
            ridx_d      = '0;
            rv_d        = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            dcnt_q       <= '0;
            rptr_q       <= '0;
            ridx_q       <= '0;
            rv_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            dcnt_q       <= dcnt_d;
            rptr_q       <= rptr_d;
            ridx_q       <= ridx_d;
            rv_q         <= rv_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef OTR_FLAG_EN
    // Sticky over-range flag for the frame currently being captured. It is
    // cleared only when FILL is (re)entered, so it survives through DRAIN and
    // is reported on that frame's eop beat.
    logic otr_flag_q, otr_flag_d;

    always_comb begin
        otr_flag_d = otr_flag_q;
        if (accept && otr) begin
            otr_flag_d = 1'b1;
        end
        if (clr) begin
            otr_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            otr_flag_q <= 1'b0;
        end else begin
            otr_flag_q <= otr_flag_d;
        end
    end

    assign frame_otr = out_valid_q && out_eop_q && otr_flag_q;
`else
    logic unused_otr;
    assign unused_otr = otr;
    assign frame_otr  = 1'b0;
`endif

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sop    = out_sop_q;
    assign out_eop    = out_eop_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_frame_cap.sv
// ----------------------------------------------------------------------------
// tb_fft_frame_cap
// Scoreboard bench for fft_frame_cap. Stimulus pushes expected beats into a
// queue; independent monitors pop and compare on every output transfer.
// A second instance with DECIM=4 covers decimation.
// ----------------------------------------------------------------------------
module tb_fft_frame_cap;

    typedef struct packed {
        logic [11:0] data;
        logic        sop;
        logic        eop;
        logic        otr;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cont;
    logic        sample_en;
    logic [10:0] sample_in;
    logic        otr;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic        frame_otr;
    logic        busy;
    logic        frame_done;

    logic        start4;
    logic        cont4;
    logic        sample_en4;
    logic [10:0] sample_in4;
    logic        otr4;
    logic        out_valid4;
    logic        out_ready4;
    logic [11:0] out_data4;
    logic        out_sop4;
    logic        out_eop4;
    logic        frame_otr4;
    logic        busy4;
    logic        frame_done4;

    beat_t exp_q[$];
    beat_t exp4_q[$];
    beat_t mon_e;
    beat_t mon4_e;

    int    pass_cnt = 0;
    int    chk_cnt  = 0;
    int    beats_seen = 0;
    int    eop_cnt  = 0;
    int    done_cnt = 0;
    int    eop4_cnt = 0;
    logic  bp_mode  = 1'b0;
    logic  done_pending = 1'b0;
    logic  stall_prev   = 1'b0;
    logic [13:0] stall_snap = '0;

    fft_frame_cap #(.DECIM(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cont       (cont),
        .sample_en  (sample_en),
        .sample_in  (sample_in),
        .otr        (otr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .frame_otr  (frame_otr),
        .busy       (busy),
        .frame_done (frame_done)
    );

    fft_frame_cap #(.DECIM(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .cont       (cont4),
        .sample_en  (sample_en4),
        .sample_in  (sample_in4),
        .otr        (otr4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready4),
        .out_data   (out_data4),
        .out_sop    (out_sop4),
        .out_eop    (out_eop4),
        .frame_otr  (frame_otr4),
        .busy       (busy4),
        .frame_done (frame_done4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ready driver: held high, or toggling every cycle in backpressure mode.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_mode ? ~out_ready : 1'b1;
        end
    end

    // Monitor for the DECIM=1 instance.
    always @(negedge clk) begin
        if (rst) begin
            done_pending = 1'b0;
            stall_prev   = 1'b0;
        end else begin
            if (done_pending) begin
                check("frame_done_after_eop", frame_done, 1);
                done_pending = 1'b0;
            end
            if (frame_done) done_cnt++;
            if (stall_prev) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_beat_stable", {out_data, out_sop, out_eop}, stall_snap);
            end
            if (out_valid && out_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_data", out_data, mon_e.data);
                    check("beat_sop", out_sop, mon_e.sop);
                    check("beat_eop", out_eop, mon_e.eop);
                    check("beat_frame_otr", frame_otr, mon_e.otr);
                end
                if (out_eop) begin
                    eop_cnt++;
                    done_pending = 1'b1;
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_snap = {out_data, out_sop, out_eop};
        end
    end

    // Monitor for the DECIM=4 instance.
    always @(negedge clk) begin
        if (!rst && out_valid4 && out_ready4) begin
            if (exp4_q.size() == 0) begin
                check("d4_unexpected_beat", 1, 0);
            end else begin
                mon4_e = exp4_q.pop_front();
                check("d4_beat_data", out_data4, mon4_e.data);
                check("d4_beat_sop", out_sop4, mon4_e.sop);
                check("d4_beat_eop", out_eop4, mon4_e.eop);
            end
            if (out_eop4) eop4_cnt++;
        end
    end

    // Feeds one 256-sample frame, sample i = base + dir*i, otr on otr_idx.
    task automatic feed(input int base, input int dir, input int otr_idx);
        logic  fo;
        beat_t b;
`ifdef OTR_FLAG_EN
        fo = (otr_idx >= 0);
`else
        fo = 1'b0;
`endif
        for (int i = 0; i < 256; i++) begin
            sample_en = 1'b1;
            sample_in = 11'(base + dir * i);
            otr       = (i == otr_idx);
            b.data    = 12'(base + dir * i - 1023);
            b.sop     = (i == 0);
            b.eop     = (i == 255);
            b.otr     = (i == 255) && fo;
            exp_q.push_back(b);
            tick();
        end
        sample_en = 1'b0;
        otr       = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 3000) begin
            tick();
            t++;
        end
        check(name, (!busy && exp_q.size() == 0), 1);
        repeat (3) tick();
    endtask

    task automatic wait_beats(input int target);
        int t;
        t = 0;
        while (beats_seen < target && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("wait_beats_reached", (beats_seen >= target), 1);
    endtask

    int d0, e0, b0, t;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cont       = 1'b0;
        sample_en  = 1'b0;
        sample_in  = '0;
        otr        = 1'b0;
        start4     = 1'b0;
        cont4      = 1'b0;
        sample_en4 = 1'b0;
        sample_in4 = '0;
        otr4       = 1'b0;
        out_ready4 = 1'b1;

        // Reset state.
        repeat (3) tick();
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_flags", {out_sop, out_eop, frame_otr, busy, frame_done}, 0);
        check("reset_out_data", out_data, 0);
        tick();
        rst = 1'b0;
        tick();

        // Ramp, no backpressure: outputs 0..255.
        d0 = done_cnt; e0 = eop_cnt;
        pulse_start();
        feed(1023, 1, -1);
        wait_idle("ramp_drained");
        check("ramp_frame_done_count", done_cnt - d0, 1);
        check("ramp_eop_count", eop_cnt - e0, 1);
        check("ramp_busy_low", busy, 0);

        // Same ramp with out_ready toggling.
        d0 = done_cnt; e0 = eop_cnt; b0 = beats_seen;
        bp_mode = 1'b1;
        pulse_start();
        feed(1023, 1, -1);
        wait_idle("bp_drained");
        bp_mode = 1'b0;
        tick();
        check("bp_transfer_count", beats_seen - b0, 256);
        check("bp_frame_done_count", done_cnt - d0, 1);

        // Restart during DRAIN: start lands on the edge beat 99 transfers.
        pulse_start();
        feed(1023, 1, -1);
        b0 = beats_seen;
        wait_beats(b0 + 100);
        d0 = done_cnt; e0 = eop_cnt; b0 = beats_seen;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("restart_valid_low", out_valid, 0);
        check("restart_busy", busy, 1);
        tick();
        feed(2046, -1, -1);
        wait_idle("restart_drained");
        check("restart_full_frame", beats_seen - b0, 256);
        check("restart_frame_done_count", done_cnt - d0, 1);
        check("restart_eop_count", eop_cnt - e0, 1);

        // Continuous mode, over-range on sample 10 of frame 1 only.
        d0 = done_cnt; e0 = eop_cnt;
        cont = 1'b1;
        pulse_start();
        feed(1023, 1, 10);
        t = 0;
        while (!frame_done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("cont_frame1_done", frame_done, 1);
        check("cont_still_busy", busy, 1);
        tick();
        cont = 1'b0;
        feed(1500, -1, -1);
        wait_idle("cont_drained");
        check("cont_frame_done_count", done_cnt - d0, 2);
        check("cont_eop_count", eop_cnt - e0, 2);

        // Decimation by 4 on the second instance: outputs 3, 7, ..., 1023.
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            beat_t b;
            sample_en4 = 1'b1;
            sample_in4 = 11'(1023 + i);
            if ((i % 4) == 3) begin
                b.data = 12'(i);
                b.sop  = (i == 3);
                b.eop  = (i == 1023);
                b.otr  = 1'b0;
                exp4_q.push_back(b);
            end
            tick();
        end
        sample_en4 = 1'b0;
        t = 0;
        while ((busy4 || exp4_q.size() != 0) && t < 3000) begin
            tick();
            t++;
        end
        check("d4_drained", (!busy4 && exp4_q.size() == 0), 1);
        check("d4_eop_count", eop4_cnt, 1);

        // Reset held for 3 cycles during an active DRAIN.
        pulse_start();
        feed(1023, 1, -1);
        b0 = beats_seen;
        wait_beats(b0 + 20);
        d0 = done_cnt; e0 = eop_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_flags", {out_sop, out_eop, frame_otr, busy, frame_done}, 0);
        check("rst_mid_out_data", out_data, 0);
        tick();
        tick();
        tick();
        exp_q.delete();
        rst = 1'b0;
        repeat (300) tick();
        check("rst_no_eop", eop_cnt - e0, 0);
        check("rst_no_frame_done", done_cnt - d0, 0);
        check("rst_idle", {busy, out_valid}, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
